// File: rtl/inv_witness_pkg.sv
// Shared types and helpers for the witness search engine and its candidate evaluator.
package inv_witness_pkg;

   typedef enum logic [1:0] {
      OP_LSHR = 2'b00,
      OP_ASHR = 2'b01,
      OP_SHL  = 2'b10
   } op_e;

   typedef enum logic {
      PRED_ULT = 1'b0,
      PRED_SLT = 1'b1
   } pred_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Size of the candidate space for a given operand width.
   function automatic int unsigned max_iter(input int unsigned w);
      return 32'd1 << w;
   endfunction

endpackage

// File: rtl/inv_witness_eval.sv
// Combinational test of one candidate: hit = PRED(OP(cand, s), t).
module inv_witness_eval
   import inv_witness_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] cand,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] t,
   input  logic [1:0]       op,
   input  logic             pred,
   output logic             hit
);

   logic             s_big;
   logic [WIDTH-1:0] sh_lshr;
   logic [WIDTH-1:0] sh_ashr;
   logic [WIDTH-1:0] sh_shl;
   logic [WIDTH-1:0] sh;

   // Shift amounts of WIDTH or more saturate rather than relying on operator behaviour.
   assign s_big   = ({1'b0, s} >= (WIDTH+1)'(WIDTH));
   assign sh_lshr = s_big ? '0 : (cand >> s);
   assign sh_shl  = s_big ? '0 : (cand << s);
   assign sh_ashr = s_big ? {WIDTH{cand[WIDTH-1]}} : WIDTH'($signed(cand) >>> s);

   always_comb begin
      sh = sh_lshr;
      case (op)
         OP_ASHR: sh = sh_ashr;
         OP_SHL:  sh = sh_shl;
         default: sh = sh_lshr;
      endcase
   end

   always_comb begin
      hit = 1'b0;
      if (pred == PRED_SLT) hit = ($signed(sh) < $signed(t));
      else                  hit = (sh < t);
   end

endmodule

// File: rtl/inv_witness_search.sv
// Sequential witness search: walks candidates from seed (wrapping) until the
// shift/compare predicate holds, the space is exhausted, or abort is raised.
module inv_witness_search
   import inv_witness_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = WIDTH + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op_sel,
   input  logic             pred_sel,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] t,
   input  logic [WIDTH-1:0] seed,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] x,
   output logic             found,
   output logic             aborted,
   output logic [CNT_W-1:0] iters
);

   localparam logic [CNT_W-1:0] ITER_MAX = CNT_W'(max_iter(WIDTH));

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   pred_e            pred_q, pred_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] t_q, t_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] iters_q, iters_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic             found_q, found_d;
   logic             aborted_q, aborted_d;
   logic [CNT_W-1:0] iters_inc;
   logic             hit;

   inv_witness_eval #(.WIDTH(WIDTH)) u_eval (
      .cand (cand_q),
      .s    (s_q),
      .t    (t_q),
      .op   (op_q),
      .pred (pred_q),
      .hit  (hit)
   );

   assign iters_inc = iters_q + CNT_W'(1);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      pred_d    = pred_q;
      s_d       = s_q;
      t_d       = t_q;
      cand_d    = cand_q;
      iters_d   = iters_q;
      x_d       = x_q;
      found_d   = found_q;
      aborted_d = aborted_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // The reserved encoding falls back to a logical shift.
               op_d    = (op_sel == 2'b11) ? OP_LSHR : op_e'(op_sel);
               pred_d  = pred_e'(pred_sel);
               s_d     = s;
               t_d     = t;
               cand_d  = seed;
               iters_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               x_d       = '0;
               found_d   = 1'b0;
               aborted_d = 1'b1;
               state_d   = DONE;
            end else if (hit) begin
               x_d     = cand_q;
               found_d = 1'b1;
               iters_d = iters_inc;
               state_d = DONE;
            end else if (iters_inc == ITER_MAX) begin
               x_d     = '0;
               found_d = 1'b0;
               iters_d = iters_inc;
               state_d = DONE;
            end else begin
               cand_d  = cand_q + WIDTH'(1);
               iters_d = iters_inc;
            end
         end
         DONE: begin
            if (out_ready) begin
               x_d       = '0;
               found_d   = 1'b0;
               aborted_d = 1'b0;
               iters_d   = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= OP_LSHR;
         pred_q    <= PRED_ULT;
         s_q       <= '0;
         t_q       <= '0;
         cand_q    <= '0;
         iters_q   <= '0;
         x_q       <= '0;
         found_q   <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         pred_q    <= pred_d;
         s_q       <= s_d;
         t_q       <= t_d;
         cand_q    <= cand_d;
         iters_q   <= iters_d;
         x_q       <= x_d;
         found_q   <= found_d;
         aborted_q <= aborted_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign x         = x_q;
   assign found     = found_q;
   assign aborted   = aborted_q;
   assign iters     = iters_q;

endmodule

// File: tb/tb_inv_witness_search.sv
// Directed bench for inv_witness_search at WIDTH=4 with hand-computed expectations.
module tb_inv_witness_search;

   localparam int WIDTH = 4;
   localparam int CNT_W = WIDTH + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       op_sel = 2'b00;
   logic             pred_sel = 1'b0;
   logic [WIDTH-1:0] s = '0;
   logic [WIDTH-1:0] t = '0;
   logic [WIDTH-1:0] seed = '0;
   logic             abort = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] x;
   logic             found;
   logic             aborted;
   logic [CNT_W-1:0] iters;

   int checks = 0;
   int errors = 0;

   inv_witness_search #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_sel(op_sel), .pred_sel(pred_sel),
      .s(s), .t(t), .seed(seed), .abort(abort),
      .out_valid(out_valid), .out_ready(out_ready),
      .x(x), .found(found), .aborted(aborted), .iters(iters)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present a request and hold in_valid across one rising edge; returns at edge+1.
   task automatic start_req(input logic [1:0] op, input logic pr, input logic [3:0] sv,
                            input logic [3:0] tv, input logic [3:0] sd);
      op_sel = op; pred_sel = pr; s = sv; t = tv; seed = sd;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count edges until out_valid, bounded so a stuck DUT cannot hang the run.
   task automatic wait_done(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic pop_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || x !== 4'h0 || found !== 1'b0 ||
          aborted !== 1'b0 || iters !== 5'd0) begin
         errors++;
         $display("FAIL reset_values: rdy=%b ov=%b x=%h f=%b a=%b it=%0d required 1 0 0 0 0 0",
                  in_ready, out_valid, x, found, aborted, iters);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic run_case1(input string tag);
      int lat;
      start_req(2'b00, 1'b1, 4'd0, 4'h0, 4'h0);
      wait_done(lat);
      checks++;
      if (lat !== 9 || x !== 4'h8 || found !== 1'b1 || aborted !== 1'b0 || iters !== 5'd9) begin
         errors++;
         $display("FAIL %s: lat=%0d x=%h f=%b a=%b it=%0d required lat=9 x=8 f=1 a=0 it=9",
                  tag, lat, x, found, aborted, iters);
      end
   endtask

   task automatic test_lshr_slt_hit();
      run_case1("lshr_slt_hit");
      pop_result();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || x !== 4'h0 || found !== 1'b0 || iters !== 5'd0) begin
         errors++;
         $display("FAIL handshake_clear: rdy=%b ov=%b x=%h f=%b it=%0d required 1 0 0 0 0",
                  in_ready, out_valid, x, found, iters);
      end
   endtask

   task automatic test_exhaust();
      int lat;
      start_req(2'b00, 1'b1, 4'd1, 4'h0, 4'h0);
      wait_done(lat);
      checks++;
      if (lat !== 16 || x !== 4'h0 || found !== 1'b0 || aborted !== 1'b0 || iters !== 5'd16) begin
         errors++;
         $display("FAIL exhaust: lat=%0d x=%h f=%b a=%b it=%0d required lat=16 x=0 f=0 a=0 it=16",
                  lat, x, found, aborted, iters);
      end
      pop_result();
   endtask

   task automatic test_ashr_oversize();
      int lat;
      start_req(2'b01, 1'b1, 4'd5, 4'h0, 4'hE);
      wait_done(lat);
      checks++;
      if (lat !== 1 || x !== 4'hE || found !== 1'b1 || iters !== 5'd1) begin
         errors++;
         $display("FAIL ashr_big_seedE: lat=%0d x=%h f=%b it=%0d required lat=1 x=e f=1 it=1",
                  lat, x, found, iters);
      end
      pop_result();
      start_req(2'b01, 1'b1, 4'd5, 4'h0, 4'h7);
      wait_done(lat);
      checks++;
      if (lat !== 2 || x !== 4'h8 || found !== 1'b1 || iters !== 5'd2) begin
         errors++;
         $display("FAIL ashr_big_seed7: lat=%0d x=%h f=%b it=%0d required lat=2 x=8 f=1 it=2",
                  lat, x, found, iters);
      end
      pop_result();
   endtask

   // Reserved op 11 acts as lshr; seed E misses E and F, wraps, and hits 0 < 1.
   task automatic test_wrap();
      int lat;
      start_req(2'b11, 1'b0, 4'd0, 4'h1, 4'hE);
      wait_done(lat);
      checks++;
      if (lat !== 3 || x !== 4'h0 || found !== 1'b1 || iters !== 5'd3) begin
         errors++;
         $display("FAIL wrap: lat=%0d x=%h f=%b it=%0d required lat=3 x=0 f=1 it=3",
                  lat, x, found, iters);
      end
      pop_result();
   endtask

   task automatic test_shl_ult();
      int lat;
      start_req(2'b10, 1'b0, 4'd2, 4'h4, 4'h5);
      wait_done(lat);
      checks++;
      if (lat !== 4 || x !== 4'h8 || found !== 1'b1 || iters !== 5'd4) begin
         errors++;
         $display("FAIL shl_ult: lat=%0d x=%h f=%b it=%0d required lat=4 x=8 f=1 it=4",
                  lat, x, found, iters);
      end
      pop_result();
   endtask

   task automatic test_abort_hold();
      start_req(2'b00, 1'b1, 4'd1, 4'h0, 4'h0);
      repeat (4) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || x !== 4'h0 || found !== 1'b0 || aborted !== 1'b1 || iters !== 5'd4) begin
         errors++;
         $display("FAIL abort: ov=%b x=%h f=%b a=%b it=%0d required ov=1 x=0 f=0 a=1 it=4",
                  out_valid, x, found, aborted, iters);
      end
      for (int i = 0; i < 3; i++) begin
         abort = (i == 1);
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || found !== 1'b0 || aborted !== 1'b1 ||
             iters !== 5'd4) begin
            errors++;
            $display("FAIL hold_%0d: ov=%b rdy=%b f=%b a=%b it=%0d required ov=1 rdy=0 f=0 a=1 it=4",
                     i, out_valid, in_ready, found, aborted, iters);
         end
      end
      abort = 1'b0;
      pop_result();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || aborted !== 1'b0 || iters !== 5'd0) begin
         errors++;
         $display("FAIL abort_release: rdy=%b ov=%b a=%b it=%0d required rdy=1 ov=0 a=0 it=0",
                  in_ready, out_valid, aborted, iters);
      end
   endtask

   task automatic test_async_reset();
      start_req(2'b00, 1'b1, 4'd1, 4'h0, 4'h0);
      repeat (3) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || x !== 4'h0 || found !== 1'b0 ||
          aborted !== 1'b0 || iters !== 5'd0) begin
         errors++;
         $display("FAIL async_reset: rdy=%b ov=%b x=%h f=%b a=%b it=%0d required 1 0 0 0 0 0",
                  in_ready, out_valid, x, found, aborted, iters);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run_case1("after_reset_case1");
   endtask

   // Result of case 1 is pending; consume it and present a new request on the same edge.
   task automatic test_back_to_back();
      int lat;
      op_sel = 2'b10; pred_sel = 1'b0; s = 4'd2; t = 4'h4; seed = 4'h5;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_handshake: rdy=%b ov=%b required rdy=1 ov=0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: rdy=%b required 0", in_ready);
      end
      wait_done(lat);
      checks++;
      if (lat !== 4 || x !== 4'h8 || found !== 1'b1 || iters !== 5'd4) begin
         errors++;
         $display("FAIL b2b_result: lat=%0d x=%h f=%b it=%0d required lat=4 x=8 f=1 it=4",
                  lat, x, found, iters);
      end
      pop_result();
   endtask

   initial begin
      test_reset();
      test_lshr_slt_hit();
      test_exhaust();
      test_ashr_oversize();
      test_wrap();
      test_shl_ult();
      test_abort_hold();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
